// File: rtl/skid_register.sv
// skid_register: elastic single-stage pipeline register with a 2-entry skid
// buffer. valid/ready on both sides; in_ready, out_valid and out_data are
// registered, so no combinational path crosses the block.
// Optional build macro: SKID_REGISTER_STALL_CNT_EN enables the saturating
// stall counter on stall_cnt; otherwise stall_cnt is tied to zero.
module skid_register #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_skid;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_load_out_in;
  logic                  w_load_out_skid;
  logic                  w_load_skid;
  logic                  w_out_valid_nxt;
  logic                  w_in_ready_nxt;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and datapath load selects; unused code recovers to EMPTY.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt   = BUSY;
          w_load_out_in = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt     = BUSY;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    w_out_valid_nxt = (w_state_nxt == BUSY) || (w_state_nxt == FULL);
    w_in_ready_nxt  = (w_state_nxt != FULL);
  end

  // State, handshake flags and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_data  <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      if (w_load_out_in) begin
        r_out_data <= in_data;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef SKID_REGISTER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Count cycles the consumer stalls a valid word; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_skid_register.sv
// Self-checking bench for skid_register: scoreboard queue of accepted words,
// occupancy model for in_ready/out_valid, and a stall counter model.
module tb_skid_register;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int            checks;
  int            errors;
  logic [DW-1:0] sb[$];
  logic [CW-1:0] exp_stall;
  logic [DW-1:0] seq_cnt;

  skid_register #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: update scoreboard from the handshakes, advance, check model.
  task automatic cycle();
    logic          in_f;
    logic          out_f;
    logic          hold;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    logic          exp_ov;
    logic          exp_ir;
    logic [CW-1:0] exp_sc;
    in_f = in_valid && in_ready;
    out_f = out_valid && out_ready;
    hold = !rst && out_valid && !out_ready;
    held = out_data;
    if (rst) begin
      sb.delete();
      exp_stall = '0;
    end else begin
      if (sb.size() > 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + CW'(1);
      if (out_f) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: out_data=%h, required no valid word", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL pop_data: out_data=%h, required %h", out_data, exp);
          end
        end
      end
      if (in_f) sb.push_back(in_data);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL hold_stable: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, held);
      end
    end
    exp_ov = (sb.size() > 0);
    exp_ir = (sb.size() < 2);
`ifdef SKID_REGISTER_STALL_CNT_EN
    exp_sc = exp_stall;
`else
    exp_sc = '0;
`endif
    checks++;
    if (out_valid !== exp_ov || in_ready !== exp_ir || stall_cnt !== exp_sc) begin
      errors++;
      $display("FAIL model_flags: out_valid=%b in_ready=%b stall_cnt=%0d, required %b %b %0d",
               out_valid, in_ready, stall_cnt, exp_ov, exp_ir, exp_sc);
    end
  endtask

  // Empty the block with out_ready high; bounded.
  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%b od=%h ir=%b sc=%0d, required 0 00000000 1 0",
               out_valid, out_data, in_ready, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data = DW'(i);
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: ov=%b od=%h ir=%b, required 1 %h 1", i, out_valid, out_data, in_ready, DW'(i));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA;
    cycle();
    in_data = 32'hB;
    cycle();
    in_valid = 1'b0;
    in_data = 32'hFFFF_FFFF;
    cycle();
    cycle();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: ir=%b od=%h, required 0 0000000a", in_ready, out_data);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hB) begin
      errors++;
      $display("FAIL bp_first_pop: ir=%b ov=%b od=%h, required 1 1 0000000b", in_ready, out_valid, out_data);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: ov=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    seq_cnt = '0;
    for (int i = 0; i < 10000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = in_valid ? seq_cnt : DW'($urandom);
      if (in_valid && in_ready) seq_cnt = seq_cnt + DW'(1);
      cycle();
    end
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    cycle();
    in_data = 32'h22;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: ir=%b, required 0", in_ready);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b ir=%b od=%h, required 0 1 00000000", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_stall_cnt();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h55;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
`ifdef SKID_REGISTER_STALL_CNT_EN
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: stall_cnt=%0d, required 15", stall_cnt);
    end
`else
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_off: stall_cnt=%0d, required 0", stall_cnt);
    end
`endif
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_stall_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
